// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fulladder.sv
// One-bit full adder used by the serial datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule : fulladder

// File: rtl/serial_adder.sv
// Bit-serial adder: adds one bit pair per cycle, LSB first, and reports the
// WIDTH-bit result plus carry-out through registered outputs.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] psum_d;

  fulladder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (c_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign psum_d = {fa_sum, psum_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q    <= fa_carry;
          psum_q <= psum_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= psum_d;
            carry_q <= fa_carry;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit vector table plus multi-cycle
// corner sequences, then an exhaustive sweep of a 2-bit instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum;
  logic       carry;

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2;
  logic [1:0] sum2;
  logic       carry2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] prev_sum   = '0;
  logic       prev_carry = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .carry (carry2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns after 12 cycles.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input int glitch_n,
                      output logic [7:0] rs, output logic rc, output int lat,
                      output int bcnt, output int dcnt, output logic hold_ok);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0; bcnt = 0; dcnt = 0; hold_ok = 1'b1; rs = '0; rc = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) begin
          lat = n + 1;
          rs  = sum;
          rc  = carry;
        end
      end
      if (n < 8 && (sum !== prev_sum || carry !== prev_carry)) hold_ok = 1'b0;
      if (n == glitch_n) begin
        start = 1'b1; a = 8'h11; b = 8'h11; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc;
    logic       hold_ok;
    int         lat, bcnt, dcnt;
    int         last_done, n_done, gap_bad;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    a = 8'h5C; b = 8'h3A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'h00);
    check("reset_carry", 32'(carry), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, -1, rs, rc, lat, bcnt, dcnt, hold_ok);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_carry", i), 32'(rc), 32'(vecs[i].exp_carry));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd8);
      check($sformatf("vec%0d_done_pulses", i), 32'(dcnt), 32'd1);
      check($sformatf("vec%0d_hold_prev", i), 32'(hold_ok), 32'd1);
      prev_sum = vecs[i].exp_sum; prev_carry = vecs[i].exp_carry;
    end

    // start re-pulsed with new operands while in ADD
    run8(8'h03, 8'h04, 1'b0, 2, rs, rc, lat, bcnt, dcnt, hold_ok);
    check("restart_ignored_sum", 32'(rs), 32'h07);
    check("restart_ignored_carry", 32'(rc), 32'd0);
    check("restart_done_pulses", 32'(dcnt), 32'd1);
    check("restart_busy_cycles", 32'(bcnt), 32'd8);
    check("restart_final_sum", 32'(sum), 32'h07);
    prev_sum = 8'h07; prev_carry = 1'b0;

    // start held high: one result every 10 cycles
    a = 8'h21; b = 8'h10; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    last_done = -1; n_done = 0; gap_bad = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        if (last_done >= 0 && n - last_done != 10) gap_bad++;
        last_done = n;
        n_done++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_done_count", 32'(n_done), 32'd4);
    check("b2b_gap_errors", 32'(gap_bad), 32'd0);
    check("b2b_sum", 32'(sum), 32'h31);
    check("b2b_carry", 32'(carry), 32'd0);
    repeat (12) @(negedge clk);

    // reset during the fourth ADD cycle
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'h00);
    check("abort_carry", 32'(carry), 32'd0);
    reset = 1'b0;
    n_done = 0; bcnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) n_done++;
      if (busy) bcnt++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_stays_idle", 32'(bcnt), 32'd0);

    // reset and start together: reset wins
    reset = 1'b1; start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_start_later_accept", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_start_sum", 32'(sum), 32'h07);

    // exhaustive 2-bit sweep
    for (int i = 0; i < 32; i++) begin
      logic [4:0] iv;
      logic [2:0] exp3;
      int         lat2;
      iv = 5'(i);
      a2 = iv[1:0]; b2 = iv[3:2]; cin2 = iv[4];
      exp3 = 3'(iv[1:0]) + 3'(iv[3:2]) + 3'(iv[4]);
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      lat2 = 0;
      for (int n = 0; n < 6; n++) begin
        if (done2 && lat2 == 0) lat2 = n + 1;
        @(negedge clk);
      end
      check($sformatf("w2_a%0d_b%0d_c%0d", iv[1:0], iv[3:2], iv[4]),
            32'({carry2, sum2}), 32'(exp3));
      check($sformatf("w2_latency_%0d", i), 32'(lat2), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL be provided: default 8, operand width in bits, legal range 2..32.
REQ-002 Port clk SHALL be: input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous, active-high reset.
REQ-004 Port start SHALL be: input, 1 bit, request to begin an addition; sampled only in IDLE.
REQ-005 Port a SHALL be: input, WIDTH bits, operand A; captured when start is accepted.
REQ-006 Port b SHALL be: input, WIDTH bits, operand B; captured when start is accepted.
REQ-007 Port cin SHALL be: input, 1 bit, carry-in; captured when start is accepted.
REQ-008 Port busy SHALL be: output, 1 bit, high while the block is in ADD.
REQ-009 Port done SHALL be: output, 1 bit, single-cycle pulse when the result becomes valid.
REQ-010 Port sum SHALL be: output, WIDTH bits, registered result of a+b+cin modulo 2^WIDTH.
REQ-011 Port carry SHALL be: output, 1 bit, registered carry-out of the addition.

Function
REQ-012 The FSM SHALL have exactly three states, with these transitions:
- IDLE -> ADD on start=1.
- ADD -> DONE after WIDTH bit-cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 On the edge where start is accepted in IDLE, the block SHALL:
- load a and b into shift registers;
- load cin into the carry flop;
- clear the bit counter.
REQ-014 Each ADD edge SHALL add exactly one bit pair, LSB first:
- full-add a_sh[0], b_sh[0] and the carry flop;
- shift the sum bit into the partial-sum register from the MSB end;
- shift a_sh and b_sh right by one;
- update the carry flop with the carry-out;
- increment the counter.
REQ-015 On the WIDTH-th ADD edge, the block SHALL:
- copy the completed partial sum into sum;
- copy the final carry into carry;
- enter DONE.
REQ-016 Latency SHALL be fixed: with start accepted at edge E0, done is high for exactly the cycle following edge E0+WIDTH, i.e. WIDTH+1 cycles after E0.
REQ-017 sum and carry SHALL change only on the REQ-015 edge or on reset, and SHALL hold the last result otherwise, including through later ADD periods.
REQ-018 start SHALL be ignored in ADD and DONE: no restart, no operand reload, no effect on the result.
REQ-019 Operand changes on a, b or cin after acceptance SHALL NOT affect the operation in progress.
REQ-020 Back-to-back operation SHALL be supported: start held high continuously yields one result every WIDTH+2 cycles.
REQ-021 Operand boundaries SHALL be handled correctly; all-ones+all-ones+1 yields sum=all-ones and carry=1.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-023 reset=1 at a rising edge SHALL force the following state:
- FSM to IDLE;
- busy=0 and done=0;
- sum=0 and carry=0;
- shift registers, carry flop and counter to 0.
REQ-024 Reset asserted mid-operation SHALL abort the addition with no done pulse, and SHALL clear sum and carry.
REQ-025 With reset and start both high, reset SHALL win, and start SHALL be honoured only on a later edge with reset=0.

Structure
REQ-026 The FSM state encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) SHALL reside in the shared package serial_adder_pkg.
REQ-027 The per-bit addition SHALL instantiate the existing one-bit fulladder module (inputs a, b, c; outputs sum, carry) as the single sub-module, and SHALL NOT use an inline '+' operator.
REQ-028 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-029 The bench SHALL cover these directed scenarios at WIDTH=8:
- a=0x00, b=0x00, cin=0 -> sum=0x00, carry=0; done exactly 9 cycles after the accepting edge.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, carry=1; busy high for exactly 8 cycles.
- start pulsed again during ADD with a=0x11 -> ignored; result of the first operation unchanged; one done pulse only.
- reset asserted on ADD cycle 4 -> no done pulse; sum=0x00 and carry=0 next cycle; FSM back to IDLE.
REQ-030 The bench SHALL run exhaustively at WIDTH=2, covering all 32 combinations of a, b and cin, each checked against a+b+cin.
